// File: rtl/pattern_sequencer.sv
// Test-pattern sequencer: cycles BARS/CHECKER/RAMP/WHITE every HOLD_FRAMES frames.
// Define PATTERN_BTN_EN to add a debounced manual-advance button (btn).
module pattern_sequencer #(
  parameter int unsigned HOLD_FRAMES     = 120,
  parameter int unsigned VSYNC_POLARITY  = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 60000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       display_on,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
`ifdef PATTERN_BTN_EN
  input  logic       btn,
`endif
  output logic [2:0] rgb,
  output logic [1:0] pattern,
  output logic       frame_tick
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    CHECKER = 2'd1,
    RAMP    = 2'd2,
    WHITE   = 2'd3
  } pat_t;

  pat_t             state;
  pat_t             state_next;
  logic             vs_q;
  logic [CNT_W-1:0] frame_cnt;
  logic             vs_act_c;
  logic             tick_c;
  logic             hold_done_c;
  logic             pending_c;
  logic             advance_c;
  logic [2:0]       color_c;
  logic             unused_bits_c;

  // vsync is data only; normalise so that 1 always means "asserted"
  assign vs_act_c    = (VSYNC_POLARITY != 0) ? ~vsync : vsync;
  assign tick_c      = vs_act_c & ~vs_q;
  assign hold_done_c = (frame_cnt == CNT_W'(HOLD_FRAMES - 1));
  // a pending press and hold expiry on the same tick collapse into one advance
  assign advance_c   = tick_c & (hold_done_c | pending_c);
  assign pattern     = state;
  assign unused_bits_c = ^{hpos[8], hpos[4:0], vpos[8:6], vpos[4:0]};

`ifdef PATTERN_BTN_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic            btn_s1;
  logic            btn_s2;
  logic            btn_db;
  logic            pending;
  logic [DB_W-1:0] db_cnt;
  logic            db_done_c;
  logic            rise_c;

  assign db_done_c = (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign rise_c    = btn_s2 & ~btn_db & db_done_c;
  assign pending_c = pending;

  // synchroniser, debouncer and press-pending flag
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      btn_db  <= 1'b0;
      db_cnt  <= '0;
      pending <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_done_c) begin
        btn_db <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      pending <= (pending & ~tick_c) | rise_c;
    end
  end
`else
  assign pending_c = 1'b0;
`endif

  // state register, frame counter, tick and registered colour
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BARS;
      vs_q       <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      rgb        <= 3'b000;
    end else begin
      state      <= state_next;
      vs_q       <= vs_act_c;
      frame_tick <= tick_c;
      if (tick_c) begin
        frame_cnt <= advance_c ? '0 : frame_cnt + CNT_W'(1);
      end
      rgb <= display_on ? color_c : 3'b000;
    end
  end

  // next-pattern logic
  always_comb begin
    state_next = state;
    if (advance_c) begin
      case (state)
        BARS:    state_next = CHECKER;
        CHECKER: state_next = RAMP;
        RAMP:    state_next = WHITE;
        WHITE:   state_next = BARS;
        default: state_next = BARS;
      endcase
    end
  end

  // colour for the current pixel, {b, g, r}
  always_comb begin
    color_c = 3'b000;
    case (state)
      BARS:    color_c = {~hpos[5], ~hpos[7], ~hpos[6]};
      CHECKER: color_c = (hpos[5] ^ vpos[5]) ? 3'b000 : 3'b111;
      RAMP:    color_c = hpos[7:5];
      WHITE:   color_c = 3'b111;
      default: color_c = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed self-checking bench for pattern_sequencer (HOLD_FRAMES=2 and =1 instances).
// Button scenarios are compiled in when PATTERN_BTN_EN is defined.
module tb_pattern_sequencer;

  logic       clk;
  logic       reset;
  logic       vsync;
  logic       display_on;
  logic [8:0] hpos;
  logic [8:0] vpos;
  logic       btn;
  logic [2:0] rgb_a;
  logic [1:0] pattern_a;
  logic       frame_tick_a;
  logic [2:0] rgb_b;
  logic [1:0] pattern_b;
  logic       frame_tick_b;

  int tests_run;
  int tests_failed;
  int exp_a;
  int exp_b;

  pattern_sequencer #(.HOLD_FRAMES(2), .VSYNC_POLARITY(1), .DEBOUNCE_CYCLES(4)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos),
`ifdef PATTERN_BTN_EN
    .btn        (btn),
`endif
    .rgb        (rgb_a),
    .pattern    (pattern_a),
    .frame_tick (frame_tick_a)
  );

  pattern_sequencer #(.HOLD_FRAMES(1), .VSYNC_POLARITY(1), .DEBOUNCE_CYCLES(4)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos),
`ifdef PATTERN_BTN_EN
    .btn        (btn),
`endif
    .rgb        (rgb_b),
    .pattern    (pattern_b),
    .frame_tick (frame_tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one vsync assertion (active-low), checking the tick pulse and both patterns
  task automatic frame(input string tag, input int pa, input int pb);
    vsync = 1'b0;
    step(1);
    check({tag, "_tick_a"}, 32'(frame_tick_a), 32'd1);
    check({tag, "_tick_b"}, 32'(frame_tick_b), 32'd1);
    check({tag, "_pat_a"}, 32'(pattern_a), 32'(pa));
    check({tag, "_pat_b"}, 32'(pattern_b), 32'(pb));
    step(1);
    check({tag, "_tick_end"}, 32'(frame_tick_a), 32'd0);
    vsync = 1'b1;
    step(3);
    check({tag, "_pat_hold"}, 32'(pattern_a), 32'(pa));
  endtask

  task automatic press(input int cycles);
    btn = 1'b1;
    step(cycles);
    btn = 1'b0;
    step(10);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    vsync        = 1'b1;
    display_on   = 1'b0;
    hpos         = '0;
    vpos         = '0;
    btn          = 1'b0;
    reset        = 1'b1;
    step(2);
    check("rst_pat_a", 32'(pattern_a), 32'd0);
    check("rst_pat_b", 32'(pattern_b), 32'd0);
    check("rst_rgb", 32'(rgb_a), 32'd0);
    check("rst_tick", 32'(frame_tick_a), 32'd0);
    reset = 1'b0;
    step(3);
    check("idle_tick", 32'(frame_tick_a), 32'd0);

    // HOLD=2 advances on ticks 2 and 4; HOLD=1 every tick with wrap 3->0
    frame("f1", 0, 1);
    frame("f2", 1, 2);
    frame("f3", 1, 3);
    frame("f4", 2, 0);
    frame("f5", 2, 1);

    // mid-frame reset with pattern 2 (RAMP showing a non-black pixel)
    display_on = 1'b1;
    hpos       = 9'd224;
    step(1);
    check("ramp_224", 32'(rgb_a), 32'd7);
    reset = 1'b1;
    step(1);
    check("mrst_pat", 32'(pattern_a), 32'd0);
    check("mrst_rgb", 32'(rgb_a), 32'd0);
    check("mrst_tick", 32'(frame_tick_a), 32'd0);
    reset = 1'b0;
    step(4);
    check("post_rst_tick", 32'(frame_tick_a), 32'd0);

    // BARS colours, one cycle after the position changes
    hpos = 9'd0;
    step(1);
    check("bars_0", 32'(rgb_a), 32'b111);
    hpos = 9'd32;
    step(1);
    check("bars_32", 32'(rgb_a), 32'b011);
    hpos = 9'd192;
    step(1);
    check("bars_192", 32'(rgb_a), 32'b100);
    hpos = 9'd224;
    step(1);
    check("bars_224", 32'(rgb_a), 32'b000);
    hpos = 9'd0;
    display_on = 1'b0;
    step(1);
    check("bars_blank", 32'(rgb_a), 32'b000);

    // CHECKER on a, RAMP on b
    display_on = 1'b1;
    frame("g1", 0, 1);
    frame("g2", 1, 2);
    hpos = 9'd32;
    vpos = 9'd0;
    step(1);
    check("chk_odd", 32'(rgb_a), 32'b000);
    check("ramp_32", 32'(rgb_b), 32'b001);
    vpos = 9'd32;
    step(1);
    check("chk_even", 32'(rgb_a), 32'b111);
    frame("g3", 1, 3);
    step(1);
    check("white_b", 32'(rgb_b), 32'b111);
    display_on = 1'b0;
    step(1);
    check("white_blank", 32'(rgb_b), 32'b000);

`ifdef PATTERN_BTN_EN
    do_reset();
    step(2);
    exp_b = 0;
    // glitch shorter than the debounce window
    press(2);
    exp_b = (exp_b + 1) % 4;
    frame("b_glitch", 0, exp_b);
    // press pending with counter at 1: exactly one advance
    press(10);
    exp_b = (exp_b + 1) % 4;
    frame("b_cnt1", 1, exp_b);
    exp_b = (exp_b + 1) % 4;
    frame("b_after1", 1, exp_b);
    exp_b = (exp_b + 1) % 4;
    frame("b_hold", 2, exp_b);
    // press with counter at 0: advance, counter cleared
    press(10);
    exp_b = (exp_b + 1) % 4;
    frame("b_cnt0", 3, exp_b);
    exp_b = (exp_b + 1) % 4;
    frame("b_clr", 3, exp_b);
    // held across frames: one advance only
    btn = 1'b1;
    step(10);
    exp_b = (exp_b + 1) % 4;
    frame("b_held1", 0, exp_b);
    exp_b = (exp_b + 1) % 4;
    frame("b_held2", 0, exp_b);
    btn = 1'b0;
    step(10);
    exp_b = (exp_b + 1) % 4;
    frame("b_rel", 1, exp_b);
    // two presses within one frame: one advance
    press(10);
    press(10);
    exp_b = (exp_b + 1) % 4;
    frame("b_multi", 2, exp_b);
`endif

    exp_a = 0;
    do_reset();
    step(1);
    check("final_rst", 32'(pattern_a), 32'(exp_a));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
